control_unit_pipe: RTL

- Parametrised, registered successor to the single-cycle opcode decoder.
- Accepts an opcode over a valid/ready handshake and decodes it into the datapath control word.
- Presents the word from an output register, holding memory-class ops for a configurable memory latency.
- Sits between the instruction-fetch register and the execute stage; supports flush on taken branch.

---
 rtl/control_unit_pipe_if.sv | 37 +++
 rtl/control_unit_pipe.sv | 130 +++++++++++++
 2 files changed

// File: rtl/control_unit_pipe_if.sv
// Opcode-in / control-word-out bundle for control_unit_pipe.
// master drives opcodes and consumes words; slave is the decoder block.
interface control_unit_pipe_if #(
  parameter int OPC_W = 6,
  parameter int ALU_W = 2
);
  // A transfer happens on a rising edge where valid and ready are both 1.
  // valid may not drop, and its payload may not change, until that transfer.
  // in_valid/in_ready carry opcode in; out_valid/out_ready carry the control word out.
  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] opcode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ALU_W-1:0] alu_cnt;
  logic             reg_src;
  logic             reg_wen;
  logic             alu_src;
  logic             w_src;
  logic             mem_wen;
  logic             check_immed;
  logic [1:0]       pc_cnt;
  logic             illegal;

  modport master (
    output in_valid, opcode, flush, out_ready,
    input  in_ready, out_valid, alu_cnt, reg_src, reg_wen, alu_src,
           w_src, mem_wen, check_immed, pc_cnt, illegal
  );

  modport slave (
    input  in_valid, opcode, flush, out_ready,
    output in_ready, out_valid, alu_cnt, reg_src, reg_wen, alu_src,
           w_src, mem_wen, check_immed, pc_cnt, illegal
  );
endinterface

// File: rtl/control_unit_pipe.sv
// Registered opcode decoder with valid/ready handshake, memory-latency hold and flush.
// Optional macro CU_ILLEGAL_TRAP_EN: flag out-of-table indices and block input until flush.
module control_unit_pipe #(
  parameter int OPC_W   = 6,
  parameter int ALU_W   = 2,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  control_unit_pipe_if.slave bus,
  output logic [1:0]         dbg_state
);
  localparam int IDX_W = OPC_W - ALU_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       ctrl_q;  // {check_immed, pc_cnt0, mem_wen, w_src, alu_src, reg_wen, reg_src}
  logic [ALU_W-1:0] alu_q;
  logic             pc1_q;
  logic             illegal_q;
  logic             out_valid_q;

  logic [31:0]      idx;
  logic [6:0]       dec_ctrl;
  logic             dec_mem;
  logic             dec_illegal;
  logic             hold_block;
  logic             ready;
  logic             accept;

  always_comb begin
    idx         = 32'(bus.opcode[IDX_W-1:0]);
    dec_ctrl    = '0;
    dec_mem     = 1'b0;
    dec_illegal = 1'b0;
    if (idx <= 32'd9) begin
      dec_ctrl = 7'b000_0011;
    end else if (idx == 32'd10) begin
      dec_ctrl = 7'b000_1110;
      dec_mem  = 1'b1;
    end else if (idx == 32'd11) begin
      dec_ctrl = 7'b001_1100;
      dec_mem  = 1'b1;
    end else if (idx <= 32'd13) begin
      dec_ctrl = 7'b010_0000;
    end else if (idx <= 32'd15) begin
      dec_ctrl = 7'b100_0110;
    end else begin
`ifdef CU_ILLEGAL_TRAP_EN
      dec_illegal = 1'b1;
`else
      dec_illegal = 1'b0;
`endif
    end
  end

  // An illegal word parks the block in HOLD until the execute stage flushes it.
  assign hold_block = (state == HOLD) && illegal_q;

  // HOLD also accepts, so a consumed word can be replaced on the same edge.
  always_comb begin
    ready     = rst_n && !bus.flush && !hold_block &&
                ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    dbg_state = state;
  end

  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = dec_mem ? BUSY : HOLD;
      BUSY: if (cnt == CNT_W'(1)) state_nxt = HOLD;
      HOLD: begin
        if (accept)                              state_nxt = dec_mem ? BUSY : HOLD;
        else if (bus.out_ready && !hold_block)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      ctrl_q      <= '0;
      alu_q       <= '0;
      pc1_q       <= 1'b0;
      illegal_q   <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      ctrl_q      <= dec_ctrl;
      alu_q       <= bus.opcode[OPC_W-1 -: ALU_W];
      pc1_q       <= (bus.opcode == '0);
      illegal_q   <= dec_illegal;
      cnt         <= dec_mem ? CNT_W'(MEM_LAT) : '0;
      out_valid_q <= !dec_mem;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) out_valid_q <= 1'b1;
    end else if ((state == HOLD) && bus.out_ready && !hold_block) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_cnt     = alu_q;
  assign bus.check_immed = ctrl_q[6];
  assign bus.pc_cnt      = {pc1_q, ctrl_q[5]};
  assign bus.mem_wen     = ctrl_q[4];
  assign bus.w_src       = ctrl_q[3];
  assign bus.alu_src     = ctrl_q[2];
  assign bus.reg_wen     = ctrl_q[1];
  assign bus.reg_src     = ctrl_q[0];
  assign bus.illegal     = illegal_q;
endmodule
